// File: rtl/bidir_pkg.sv
// Shared types and helpers for the bidirectional pad controller.
package bidir_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StRelease,
    StSample
  } state_e;

  // Width that holds max(a, b) - 1 with one bit of headroom.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/bidir_turn_cnt.sv
// Loadable down-counter with zero flag; parks at zero until reloaded.
module bidir_turn_cnt #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bidir_port_ctrl.sv
// Serialising master for a shared bidirectional pad: drive with readback check,
// release/turnaround, and released-pad sampling.
module bidir_port_ctrl
  import bidir_pkg::*;
#(
  parameter int unsigned W          = 1,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned TURN_CYC   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_valid,
  input  logic [W-1:0] wr_data,
  output logic         wr_ready,
  input  logic         rd_req,
  output logic         rd_ready,
  output logic         rd_valid,
  output logic [W-1:0] rd_data,
  inout  wire  [W-1:0] pad,
  output logic         oe,
  output logic         busy,
  output logic         contention,
  input  logic         contention_clr
);

  localparam int unsigned CntW = cnt_width(SETTLE_CYC, TURN_CYC);
  localparam logic [CntW-1:0] SettleLd = CntW'(SETTLE_CYC - 1);
  localparam logic [CntW-1:0] TurnLd   = CntW'(TURN_CYC - 1);

  state_e         state_q, state_d;
  logic           oe_q, oe_d;
  logic [W-1:0]   drv_q, drv_d;
  logic           pend_q, pend_d;
  logic           rd_valid_q, rd_valid_d;
  logic [W-1:0]   rd_data_q, rd_data_d;
  logic           contention_q, contention_d;
  logic           cont_set;
  logic           cnt_load;
  logic [CntW-1:0] cnt_load_val;
  logic           cnt_zero;

  bidir_turn_cnt #(
    .WIDTH(CntW)
  ) u_turn_cnt (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    oe_d         = oe_q;
    drv_d        = drv_q;
    pend_d       = pend_q;
    rd_valid_d   = 1'b0;
    rd_data_d    = rd_data_q;
    cont_set     = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    wr_ready     = 1'b0;
    rd_ready     = 1'b0;

    case (state_q)
      StIdle: begin
        wr_ready = 1'b1;
        rd_ready = ~wr_valid;
        if (wr_valid) begin
          state_d      = StDrive;
          drv_d        = wr_data;
          oe_d         = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = SettleLd;
        end else if (rd_req) begin
          state_d      = StRelease;
          pend_d       = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = TurnLd;
        end
      end
      StDrive: begin
        if (cnt_zero) begin
          // 4-state compare so a contended (X) pad is flagged too.
          cont_set = (pad !== drv_q);
          wr_ready = 1'b1;
          cnt_load = 1'b1;
          if (wr_valid) begin
            drv_d        = wr_data;
            cnt_load_val = SettleLd;
          end else begin
            state_d      = StRelease;
            oe_d         = 1'b0;
            pend_d       = 1'b0;
            cnt_load_val = TurnLd;
          end
        end
      end
      StRelease: begin
        if (cnt_zero) begin
          state_d = pend_q ? StSample : StIdle;
        end
      end
      StSample: begin
        rd_data_d  = pad;
        rd_valid_d = 1'b1;
        pend_d     = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (rst) begin
      wr_ready = 1'b0;
      rd_ready = 1'b0;
    end

    contention_d = cont_set ? 1'b1 : (contention_clr ? 1'b0 : contention_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      oe_q         <= 1'b0;
      drv_q        <= '0;
      pend_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      contention_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      oe_q         <= oe_d;
      drv_q        <= drv_d;
      pend_q       <= pend_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      contention_q <= contention_d;
    end
  end

  // Pad enable is the oe flop itself; data only ever comes from drv_q.
  assign pad        = oe_q ? drv_q : {W{1'bz}};
  assign oe         = oe_q;
  assign busy       = (state_q != StIdle);
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign contention = contention_q;

endmodule

// File: tb/tb_bidir_port_ctrl.sv
// Directed bench for bidir_port_ctrl: per-cycle vector table plus corner-case sequences.
module tb_bidir_port_ctrl;

  localparam int W = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_valid;
  logic [W-1:0] wr_data;
  logic         wr_ready;
  logic         rd_req;
  logic         rd_ready;
  logic         rd_valid;
  logic [W-1:0] rd_data;
  wire  [W-1:0] pad;
  logic         oe;
  logic         busy;
  logic         contention;
  logic         contention_clr;
  logic         far_en;
  logic [W-1:0] far_val;

  int n_cmp = 0;
  int n_bad = 0;

  always #10 clk = ~clk;

  // Far side of the pad.
  assign pad = far_en ? far_val : {W{1'bz}};

  bidir_port_ctrl #(
    .W          (W),
    .SETTLE_CYC (2),
    .TURN_CYC   (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .rd_req         (rd_req),
    .rd_ready       (rd_ready),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .pad            (pad),
    .oe             (oe),
    .busy           (busy),
    .contention     (contention),
    .contention_clr (contention_clr)
  );

  // in: {rst, wr_valid, wr_data, rd_req, far_en, far_val, contention_clr}
  // ex: {oe, pad, busy, wr_ready, rd_ready, rd_valid, rd_data, contention}
  typedef struct {
    logic [6:0] in;
    logic [7:0] ex;
  } vec_t;

  vec_t  vecs[23];
  string nm[8];

  task automatic chk(input string n, input logic a, input logic e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", n, a, e);
    end
  endtask

  task automatic wait_idle(input string n);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk({n, "_idle_timeout"}, busy, 1'b0);
  endtask

  initial begin
    logic [7:0] act;
    logic [6:0] in;

    nm[7] = "oe"; nm[6] = "pad"; nm[5] = "busy"; nm[4] = "wr_ready";
    nm[3] = "rd_ready"; nm[2] = "rd_valid"; nm[1] = "rd_data"; nm[0] = "contention";

    vecs[0]  = '{7'b1000100, 8'b00000000};  // reset, far side holds 0
    vecs[1]  = '{7'b0000100, 8'b00011000};  // idle
    vecs[2]  = '{7'b0110100, 8'b00010000};  // write 1 accepted
    vecs[3]  = '{7'b0000000, 8'b11100000};  // drive cnt 1
    vecs[4]  = '{7'b0000000, 8'b11110000};  // drive last cycle
    vecs[5]  = '{7'b0000100, 8'b00100000};  // released, far drives 0
    vecs[6]  = '{7'b0000100, 8'b00100000};
    vecs[7]  = '{7'b0001110, 8'b01011000};  // read accepted, far drives 1
    vecs[8]  = '{7'b0000110, 8'b01100000};
    vecs[9]  = '{7'b0000110, 8'b01100000};
    vecs[10] = '{7'b0000110, 8'b01100000};  // sample
    vecs[11] = '{7'b0000110, 8'b01011110};  // rd_valid at accept+4
    vecs[12] = '{7'b0101100, 8'b00010010};  // write+read together: write wins
    vecs[13] = '{7'b0001000, 8'b10100010};
    vecs[14] = '{7'b0001000, 8'b10110010};  // read still held, not accepted
    vecs[15] = '{7'b0001100, 8'b00100010};
    vecs[16] = '{7'b0001100, 8'b00100010};
    vecs[17] = '{7'b0001100, 8'b00011010};  // held read accepted
    vecs[18] = '{7'b0000100, 8'b00100010};
    vecs[19] = '{7'b0000100, 8'b00100010};
    vecs[20] = '{7'b0000100, 8'b00100010};
    vecs[21] = '{7'b0000100, 8'b00011100};  // rd_data 0
    vecs[22] = '{7'b0000100, 8'b00011000};

    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_req = 1'b0;
    contention_clr = 1'b0; far_en = 1'b1; far_val = '0;

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      in             = vecs[i].in;
      rst            = in[6];
      wr_valid       = in[5];
      wr_data        = in[4];
      rd_req         = in[3];
      far_en         = in[2];
      far_val        = in[1];
      contention_clr = in[0];
      #1;
      act = {oe, pad[0], busy, wr_ready, rd_ready, rd_valid, rd_data[0], contention};
      for (int j = 7; j >= 0; j--) begin
        chk($sformatf("v%0d_%s", i, nm[j]), act[j], vecs[i].ex[j]);
      end
    end

    // Back-to-back writes 0 then 1: oe continuous, pad 0 then 1.
    @(negedge clk); far_en = 1'b0; wr_valid = 1'b1; wr_data = 1'b0; #1;
    chk("b2b_accept_ready", wr_ready, 1'b1);
    @(negedge clk); wr_data = 1'b1; #1;
    chk("b2b_c1_oe", oe, 1'b1); chk("b2b_c1_pad", pad[0], 1'b0);
    chk("b2b_c1_wr_ready", wr_ready, 1'b0);
    @(negedge clk); #1;
    chk("b2b_c2_oe", oe, 1'b1); chk("b2b_c2_pad", pad[0], 1'b0);
    chk("b2b_c2_wr_ready", wr_ready, 1'b1);
    @(negedge clk); wr_valid = 1'b0; #1;
    chk("b2b_c3_oe", oe, 1'b1); chk("b2b_c3_pad", pad[0], 1'b1);
    @(negedge clk); #1;
    chk("b2b_c4_oe", oe, 1'b1); chk("b2b_c4_pad", pad[0], 1'b1);
    @(negedge clk); far_en = 1'b1; far_val = 1'b0; #1;
    chk("b2b_c5_oe", oe, 1'b0); chk("b2b_c5_pad_released", pad[0], 1'b0);
    wait_idle("b2b");
    chk("b2b_no_contention", contention, 1'b0);

    // Contention: write 0 while far side holds 1.
    @(negedge clk); far_en = 1'b1; far_val = 1'b1; wr_valid = 1'b1; wr_data = 1'b0; #1;
    @(negedge clk); wr_valid = 1'b0; #1;
    chk("cont_pad_not_clean", (pad === 1'b0), 1'b0);
    @(negedge clk); #1;
    chk("cont_before_compare", contention, 1'b0);
    @(negedge clk); #1;
    chk("cont_set", contention, 1'b1);
    wait_idle("cont");
    @(negedge clk); far_en = 1'b0; #1;
    chk("cont_sticky", contention, 1'b1);
    @(negedge clk); contention_clr = 1'b1; #1;
    chk("cont_clr_same_cycle", contention, 1'b1);
    @(negedge clk); contention_clr = 1'b0; #1;
    chk("cont_cleared", contention, 1'b0);

    // Set and clear on the same edge: set wins.
    @(negedge clk); far_en = 1'b1; wr_valid = 1'b1; wr_data = 1'b0; contention_clr = 1'b1; #1;
    @(negedge clk); wr_valid = 1'b0; #1;
    @(negedge clk); #1;
    chk("cont_pre_setwins", contention, 1'b0);
    @(negedge clk); contention_clr = 1'b0; #1;
    chk("cont_set_wins", contention, 1'b1);
    wait_idle("setwins");

    // Reset in the middle of DRIVE aborts cleanly and clears contention.
    @(negedge clk); far_en = 1'b0; wr_valid = 1'b1; wr_data = 1'b1; #1;
    chk("rst_pre_contention", contention, 1'b1);
    @(negedge clk); wr_valid = 1'b0; rst = 1'b1; #1;
    chk("rst_mid_oe_before", oe, 1'b1);
    chk("rst_mid_wr_ready", wr_ready, 1'b0);
    chk("rst_mid_rd_ready", rd_ready, 1'b0);
    @(negedge clk); far_en = 1'b1; far_val = 1'b0; #1;
    chk("rst_oe", oe, 1'b0); chk("rst_pad", pad[0], 1'b0);
    chk("rst_busy", busy, 1'b0); chk("rst_contention", contention, 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      chk($sformatf("rst_after%0d_rd_valid", c), rd_valid, 1'b0);
      chk($sformatf("rst_after%0d_busy", c), busy, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
